// File: rtl/pool2x2_stream.sv
// Streaming 2x2/stride-2 signed max-pooling over a raster pixel stream.
// Optional feature: define POOL_RELU_EN to clamp negative channel values to 0 before pooling.
module pool2x2_stream #(
  parameter int unsigned CH   = 32,
  parameter int unsigned DW   = 8,
  parameter int unsigned COLS = 256,
  parameter int unsigned ROWS = 16,
  // Index ports keep at least one bit so a single pooled row/column still elaborates.
  localparam int unsigned OCW = (COLS > 2) ? $clog2(COLS / 2) : 1,
  localparam int unsigned ORW = (ROWS > 2) ? $clog2(ROWS / 2) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CH*DW-1:0]     in_data,
  output logic                 out_valid,
  output logic [CH*DW-1:0]     out_data,
  output logic [OCW-1:0]       out_col,
  output logic [ORW-1:0]       out_row,
  output logic                 frame_done
);

  localparam int unsigned W  = CH * DW;
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned HC = COLS / 2;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [W-1:0]  hold;
  logic [W-1:0]  linebuf [HC];

  logic [W-1:0]   pix_c;
  logic [W-1:0]   hmax_c;
  logic [W-1:0]   pool_c;
  logic [OCW-1:0] lb_idx_c;
  logic signed [DW-1:0] h_s, p_s, m_s, l_s;

  assign lb_idx_c = OCW'(col >> 1);

  // Input conditioning: optional per-channel ReLU.
  always_comb begin
    pix_c = in_data;
`ifdef POOL_RELU_EN
    for (int k = 0; k < int'(CH); k++) begin
      if (in_data[k*DW + DW - 1]) pix_c[k*DW +: DW] = '0;
    end
`endif
  end

  // Per-channel horizontal pair max and vertical max against the stored pair.
  always_comb begin
    hmax_c = '0;
    pool_c = '0;
    h_s    = '0;
    p_s    = '0;
    m_s    = '0;
    l_s    = '0;
    for (int k = 0; k < int'(CH); k++) begin
      h_s = $signed(hold[k*DW +: DW]);
      p_s = $signed(pix_c[k*DW +: DW]);
      m_s = (p_s > h_s) ? p_s : h_s;
      l_s = $signed(linebuf[lb_idx_c][k*DW +: DW]);
      hmax_c[k*DW +: DW] = m_s;
      pool_c[k*DW +: DW] = (l_s > m_s) ? l_s : m_s;
    end
  end

  // Line buffer holds even-row pair maxima; never reset, always written before being read.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && col[0] && !row[0]) linebuf[lb_idx_c] <= hmax_c;
  end

  // Raster counters, pair register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_col    <= '0;
      out_row    <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) hold <= pix_c;
        if (col[0] && row[0]) begin
          out_valid  <= 1'b1;
          out_data   <= pool_c;
          out_col    <= lb_idx_c;
          out_row    <= ORW'(row >> 1);
          frame_done <= (col == CW'(COLS - 1)) && (row == RW'(ROWS - 1));
        end
        if (col == CW'(COLS - 1)) begin
          col <= '0;
          row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench for pool2x2_stream: a frame-level reference model predicts pooled pixels,
// a negedge monitor compares every DUT output, its timing, and output hold between pulses.
module tb_pool2x2_stream;

  localparam int unsigned DW     = 8;
  localparam int unsigned CH_A   = 32;
  localparam int unsigned COLS_A = 4;
  localparam int unsigned ROWS_A = 2;
  localparam int unsigned CH_B   = 2;
  localparam int unsigned COLS_B = 8;
  localparam int unsigned ROWS_B = 4;

  typedef struct {
    logic [255:0] data;
    int           col;
    int           row;
    logic         fd;
    longint       cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_a = 1'b1, rst_b = 1'b1;
  logic                 in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [CH_A*DW-1:0]   in_data_a = '0;
  logic [CH_B*DW-1:0]   in_data_b = '0;
  logic                 out_valid_a, out_valid_b, frame_done_a, frame_done_b;
  logic [CH_A*DW-1:0]   out_data_a;
  logic [CH_B*DW-1:0]   out_data_b;
  logic [0:0]           out_col_a, out_row_a, out_row_b;
  logic [1:0]           out_col_b;

  pool2x2_stream #(.CH(CH_A), .DW(DW), .COLS(COLS_A), .ROWS(ROWS_A)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_col(out_col_a),
    .out_row(out_row_a), .frame_done(frame_done_a));

  pool2x2_stream #(.CH(CH_B), .DW(DW), .COLS(COLS_B), .ROWS(ROWS_B)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_col(out_col_b),
    .out_row(out_row_b), .frame_done(frame_done_b));

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;
  logic   rst_seen_a = 1'b1, rst_seen_b = 1'b1;
  exp_t   q_a[$];
  exp_t   q_b[$];

  // Reference model state: raster position and the pixels of the current frame.
  int           cm[2];
  int           rm[2];
  logic [255:0] pix[2][4][8];

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rst_seen_a <= rst_a;
    rst_seen_b <= rst_b;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [255:0] relu(input int nch, input logic [255:0] d);
    logic [255:0] r = d;
`ifdef POOL_RELU_EN
    for (int k = 0; k < nch; k++) if ($signed(d[k*8 +: 8]) < 0) r[k*8 +: 8] = 8'h00;
`else
    r = d;
    if (nch < 0) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [255:0] wmax(input int nch, input logic [255:0] a, input logic [255:0] b,
                                        input logic [255:0] c, input logic [255:0] d);
    logic [255:0] r = '0;
    for (int k = 0; k < nch; k++) begin
      int m = $signed(a[k*8 +: 8]);
      if (int'($signed(b[k*8 +: 8])) > m) m = $signed(b[k*8 +: 8]);
      if (int'($signed(c[k*8 +: 8])) > m) m = $signed(c[k*8 +: 8]);
      if (int'($signed(d[k*8 +: 8])) > m) m = $signed(d[k*8 +: 8]);
      r[k*8 +: 8] = 8'(m);
    end
    return r;
  endfunction

  // One clock of stimulus on unit u, with the model updated for what the DUT will accept.
  task automatic beat(input int u, input logic v, input logic [255:0] d, input logic r);
    int nch, ncol, nrow, c, rw;
    exp_t e;
    @(negedge clk);
    if (u == 0) begin
      rst_a = r; in_valid_a = v; in_data_a = d[CH_A*DW-1:0];
      nch = CH_A; ncol = COLS_A; nrow = ROWS_A;
    end else begin
      rst_b = r; in_valid_b = v; in_data_b = d[CH_B*DW-1:0];
      nch = CH_B; ncol = COLS_B; nrow = ROWS_B;
    end
    if (r) begin
      cm[u] = 0; rm[u] = 0;
    end else if (v) begin
      c = cm[u]; rw = rm[u];
      pix[u][rw][c] = relu(nch, d);
      if ((rw % 2 == 1) && (c % 2 == 1)) begin
        e.data = wmax(nch, pix[u][rw-1][c-1], pix[u][rw-1][c], pix[u][rw][c-1], pix[u][rw][c]);
        e.col  = c / 2;
        e.row  = rw / 2;
        e.fd   = (c == ncol - 1) && (rw == nrow - 1);
        e.cyc  = cyc + 1;
        if (u == 0) q_a.push_back(e); else q_b.push_back(e);
      end
      cm[u] = (c == ncol - 1) ? 0 : c + 1;
      if (c == ncol - 1) rm[u] = (rw == nrow - 1) ? 0 : rw + 1;
    end
  endtask

  function automatic logic [255:0] rep(input int v);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[k*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: compare each pulse against the scoreboard, otherwise require reset or held values.
  logic [255:0] last_a = '0, last_b = '0;
  int lc_a = 0, lr_a = 0, lc_b = 0, lr_b = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen_a) begin
      chk("reset_a", {out_valid_a, frame_done_a, out_col_a, out_row_a, out_data_a}, '0);
      last_a = '0; lc_a = 0; lr_a = 0;
    end else if (out_valid_a) begin
      if (q_a.size() == 0) chk("spurious_a", 256'(out_valid_a), 256'(0));
      else begin
        e = q_a.pop_front();
        chk("data_a", 256'(out_data_a), e.data);
        chk("col_a", 256'(out_col_a), 256'(e.col));
        chk("row_a", 256'(out_row_a), 256'(e.row));
        chk("fdone_a", 256'(frame_done_a), 256'(e.fd));
        chk("latency_a", 256'(cyc), 256'(e.cyc));
        last_a = e.data; lc_a = e.col; lr_a = e.row;
      end
    end else begin
      chk("hold_a", {frame_done_a, 256'(out_data_a)}, {1'b0, last_a});
      chk("hold_idx_a", 256'({out_col_a, out_row_a}), 256'({1'(lc_a), 1'(lr_a)}));
    end
    if (rst_seen_b) begin
      chk("reset_b", {out_valid_b, frame_done_b, out_col_b, out_row_b, out_data_b}, '0);
      last_b = '0; lc_b = 0; lr_b = 0;
    end else if (out_valid_b) begin
      if (q_b.size() == 0) chk("spurious_b", 256'(out_valid_b), 256'(0));
      else begin
        e = q_b.pop_front();
        chk("data_b", 256'(out_data_b), e.data);
        chk("col_b", 256'(out_col_b), 256'(e.col));
        chk("row_b", 256'(out_row_b), 256'(e.row));
        chk("fdone_b", 256'(frame_done_b), 256'(e.fd));
        chk("latency_b", 256'(cyc), 256'(e.cyc));
        last_b = e.data; lc_b = e.col; lr_b = e.row;
      end
    end else begin
      chk("hold_b", {frame_done_b, 256'(out_data_b)}, {1'b0, last_b});
      chk("hold_idx_b", 256'({out_col_b, out_row_b}), 256'({2'(lc_b), 1'(lr_b)}));
    end
  end

  initial begin
    logic [255:0] d;
    logic [7:0] negf [8];
    negf = '{8'hFB, 8'hFD, 8'h01, 8'h02, 8'hF9, 8'hFE, 8'h03, 8'h04};
    cm = '{0, 0}; rm = '{0, 0};
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Ramp, then the same ramp with 3 idle cycles between beats.
    for (int i = 1; i <= 8; i++) beat(0, 1'b1, rep(i), 1'b0);
    repeat (2) beat(0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      beat(0, 1'b1, rep(i), 1'b0);
      repeat (3) beat(0, 1'b0, rnd(), 1'b0);
    end
    // Back-to-back frames.
    for (int i = 1; i <= 8; i++) beat(0, 1'b1, rep(i), 1'b0);
    for (int i = 11; i <= 18; i++) beat(0, 1'b1, rep(i), 1'b0);
    // All-negative window.
    for (int i = 0; i < 8; i++) beat(0, 1'b1, rep(int'(negf[i])), 1'b0);
    // Mid-frame reset with a simultaneous beat that must be dropped.
    for (int i = 0; i < 5; i++) beat(0, 1'b1, rnd(), 1'b0);
    beat(0, 1'b1, rnd(), 1'b1);
    for (int i = 1; i <= 8; i++) beat(0, 1'b1, rep(i), 1'b0);
    // Channel independence: channel k's maximum sits at window position k mod 4.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 32; k++) begin
          if ((r % 2) * 2 + (c % 2) == k % 4) d[k*8 +: 8] = 8'(60 + k);
          else d[k*8 +: 8] = 8'(int'($urandom_range(0, 187)) - 128);
        end
        beat(0, 1'b1, d, 1'b0);
      end
    end
    // Random gapped frames on both configurations, with occasional resets on the larger one.
    for (int i = 0; i < 40; i++) beat(0, 1'($urandom_range(0, 2) != 0), rnd(), 1'b0);
    for (int i = 0; i < 400; i++)
      beat(1, 1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 79) == 0));
    repeat (4) beat(0, 1'b0, '0, 1'b0);
    repeat (4) beat(1, 1'b0, '0, 1'b0);
    chk("drain_a", 256'(q_a.size()), 256'(0));
    chk("drain_b", 256'(q_b.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool2x2_stream.md
# pool2x2_stream

Streaming 2x2/stride-2 max-pooling stage directly downstream of the convolution core. It consumes the registered convolution sums, one pixel (all filter channels) per valid beat in raster order, and keeps a half-width line buffer of horizontal pair maxima. It emits one pooled pixel per completed 2x2 window to the output SRAM writer.

## Interface
Parameters:
- `CH`, 32: filter channels per beat (matches filter count).
- `DW`, 8: bits per channel value, two's-complement signed.
- `COLS`, 256: feature-map width in pixels; must be even and ≥ 2.
- `ROWS`, 16: feature-map height in pixels; must be even and ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  beat qualifier (driven by the conv core's sum-valid); no backpressure exists.
- `in_data`  in  CH*DW  one pixel; channel k occupies bits [k*DW +: DW].
- `out_valid`  out  1  pooled pixel valid, single-cycle pulse per window.
- `out_data`  out  CH*DW  pooled pixel, same channel packing.
- `out_col`  out  $clog2(COLS/2)  pooled column index of `out_data`.
- `out_row`  out  $clog2(ROWS/2)  pooled row index of `out_data`.
- `frame_done`  out  1  pulses together with the last pooled pixel of a frame.

## Operation
- Counters `col` (0..COLS-1) and `row` (0..ROWS-1) advance on each `in_valid` beat only. `col` wraps to 0 and increments `row`. `row` wraps to 0 after the last column of row ROWS-1, so frames run back-to-back.
- Even `col`: store `in_data` in the per-channel pair register `hold`.
- Odd `col`: `hmax[k] = max_signed(hold[k], in_data[k])` for every k.
  - Even `row`: write `hmax` to line buffer entry `col>>1`. COLS/2 entries of CH*DW bits each, register array or inferred RAM with synchronous write.
  - Odd `row`: `out_data[k] = max_signed(linebuf[col>>1][k], hmax[k])`. Assert `out_valid`, `out_col = col>>1`, `out_row = row>>1`.
- Comparisons are signed on DW bits. Equal values select either operand, which are identical, so there is no ambiguity. No width growth; the output is DW bits.
- `frame_done` = `out_valid` with `out_col == COLS/2-1` and `out_row == ROWS/2-1`.
- No state machine beyond the counters. The phase is fully determined by (`row[0]`, `col[0]`).

## Timing
- Reset values: `out_valid=0`, `frame_done=0`, `out_data=0`, `out_col=0`, `out_row=0`. Counters are 0; `hold` is 0.
- The line buffer is not cleared by reset. Every odd-row read is preceded by an even-row write in the same frame, so stale contents are never observed.
- Latency: outputs are registered. `out_valid` is high in the cycle after the beat at (odd row, odd col) is accepted.
- `out_data`, `out_col` and `out_row` hold their values until the next `out_valid`.
- Gaps in `in_valid` of any length are allowed. State freezes while `in_valid=0`, and `out_valid` stays low.
- Back-to-back beats give at most one `out_valid` every 2 cycles on odd rows. Even rows produce none.
- `rst` asserted mid-frame: counters return to 0 and outputs clear on the next edge. The next beat is treated as pixel (0,0).
- `rst` and `in_valid` in the same cycle: reset wins and the beat is dropped.

## Configuration
- `POOL_RELU_EN` defined: each input channel passes through ReLU before entering `hold`/compare: negative values become 0. `out_data` is then never negative, and an all-negative window yields 0.
- `POOL_RELU_EN` undefined: raw signed values are pooled. An all-negative window yields its signed maximum.

## Test plan
- Ramp: COLS=4, ROWS=2, CH=1, continuous beats of values 1..8 in raster order -> two `out_valid` pulses, data 6 then 8, cols 0 and 1, row 0. `frame_done` is high on the second pulse.
- Negative window: window values {-5,-3,-7,-2} (0xFB,0xFD,0xF9,0xFE) -> output 0xFE without `POOL_RELU_EN`, 0x00 with it.
- Gapped input: same stimulus as the ramp test with `in_valid` low for 3 cycles between every beat -> identical outputs. Each pulse occurs 1 cycle after its completing beat.
- Back-to-back frames: two consecutive 4x2 frames, the second with values 11..18 -> outputs 6,8 then 16,18. `frame_done` pulses twice. No dead cycles are required.
- Mid-frame reset: assert `rst` for 1 cycle after 5 beats, then stream a full 4x2 frame -> no output is produced from the pre-reset beats, and the output matches a clean frame exactly.
- Channel independence: CH=32, each channel k fed a distinct window whose max sits in a different position (k mod 4) -> every channel lane outputs its own maximum at the correct bit slice.
